// File: rtl/vga_map_arbiter.sv
// vga_map_arbiter
//   Shares one single-port, synchronous-read tile-map RAM (20x15 cells) between
//   the VGA renderer and game logic. The renderer gets a fixed prefetch slot
//   two pixels ahead of every 32-px tile column. tile_code is registered so it
//   is aligned to the pixel. Game-logic accesses use a req/ack handshake and
//   are placed in the cycles that the renderer does not use.
//   Optional build macro: MAP_ARB_BLANK_ONLY_EN. When it is defined, CPU
//   accesses are granted only on vertical-blanking lines, so the map never
//   changes while a frame is being drawn.
module vga_map_arbiter #(
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int TILE_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  output logic [TILE_W-1:0] tile_code,
  output logic [4:0]        tile_px,
  output logic [4:0]        tile_py,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [8:0]        cpu_addr,
  input  logic [TILE_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [TILE_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [8:0]        ram_addr,
  output logic [TILE_W-1:0] ram_wdata,
  input  logic [TILE_W-1:0] ram_rdata
);

  localparam int MAP_COLS  = 20;
  localparam int MAP_ROWS  = 15;
  localparam int MAP_CELLS = MAP_COLS * MAP_ROWS;
  localparam int ACT_LINES = 480;
  // The fetch for column c is issued 2 clocks before its first pixel. One
  // clock is for the RAM read latency and one is for the tile_code register.
  localparam int FETCH_LEAD = 2;

  // CPU-path states. The issue cycle is the granting cycle in S_IDLE, because
  // the RAM strobe comes combinationally from state and inputs. The two ACK
  // states record whether the returned data is real RAM data or forced zero.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACK_RD   = 2'd1;
  localparam logic [1:0] S_ACK_ZERO = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic              r_run;
  logic              r_fetch_d;
  logic [TILE_W-1:0] r_tile_code;

  logic [9:0] w_hrel;
  logic [9:0] w_vrel;
  logic [4:0] w_col;
  logic [3:0] w_row;
  logic       w_active_line;
  logic       w_slot_time;
  logic       w_fetch;
  logic [8:0] w_fetch_addr;
  logic       w_grant_ok;
  logic       w_cpu_grant;
  logic       w_cpu_in_range;
  logic       w_cpu_ram;

  // Horizontal offset from the first fetch slot (h_cnt = H_START-2).
  // Vertical offset from the first active line.
  assign w_hrel = h_cnt - 10'(H_START - FETCH_LEAD);
  assign w_vrel = v_cnt - 10'(V_START);
  assign w_col  = 5'(w_hrel >> 5);
  assign w_row  = 4'(w_vrel >> 5);

  assign w_active_line = (v_cnt >= 10'(V_START)) && (v_cnt < 10'(V_START + ACT_LINES));
  // A fetch slot occurs every 32 clocks from H_START-2, for columns 0..19 only.
  assign w_slot_time   = (h_cnt >= 10'(H_START - FETCH_LEAD)) && (w_hrel[4:0] == 5'd0) &&
                         (w_col < 5'(MAP_COLS));
  // r_run holds the RAM strobes off until the first clock after reset release.
  assign w_fetch       = r_run && w_active_line && w_slot_time;
  // row*20 becomes (row<<4)+(row<<2). It fits in 9 bits for row<=14, col<=19.
  assign w_fetch_addr  = 9'(w_row) * 9'(MAP_COLS) + 9'(w_col);

  assign tile_px = 5'(h_cnt - 10'(H_START));
  assign tile_py = w_vrel[4:0];

`ifdef MAP_ARB_BLANK_ONLY_EN
  // Tear-free mode: the map is changed only during vertical blanking.
  assign w_grant_ok = !w_active_line;
`else
  assign w_grant_ok = 1'b1;
`endif

  // Fetch has absolute priority. Only S_IDLE can grant, so a CPU access
  // never issues in its own ACK cycle.
  assign w_cpu_grant    = r_run && (r_state == S_IDLE) && cpu_req && !w_fetch && w_grant_ok;
  assign w_cpu_in_range = cpu_addr < 9'(MAP_CELLS);
  assign w_cpu_ram      = w_cpu_grant && w_cpu_in_range;

  // RAM port mux: fetch address, CPU address, or parked at zero.
  always_comb begin
    ram_en    = w_fetch || w_cpu_ram;
    ram_we    = w_cpu_ram && cpu_we;
    ram_addr  = 9'd0;
    ram_wdata = '0;
    if (w_fetch) begin
      ram_addr = w_fetch_addr;
    end else if (w_cpu_ram) begin
      ram_addr = cpu_addr;
      if (cpu_we) begin
        ram_wdata = cpu_wdata;
      end
    end
  end

  // CPU handshake next-state: a granted access always acks on the next cycle.
  always_comb begin
    w_state_next = S_IDLE;
    if (r_state == S_IDLE && w_cpu_grant) begin
      if (w_cpu_in_range && !cpu_we) begin
        w_state_next = S_ACK_RD;
      end else begin
        w_state_next = S_ACK_ZERO;
      end
    end
  end

  // State, run flag, fetch pipeline and tile_code register.
  // An async reset clears the state, so an in-flight access is dropped unacked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_fetch_d   <= 1'b0;
      r_tile_code <= '0;
    end else begin
      r_state   <= w_state_next;
      r_run     <= 1'b1;
      r_fetch_d <= w_fetch;
      if (r_fetch_d) begin
        r_tile_code <= ram_rdata;
      end
    end
  end

  assign tile_code = r_tile_code;
  assign cpu_ack   = (r_state != S_IDLE);
  assign cpu_rdata = (r_state == S_ACK_RD) ? ram_rdata : '0;

endmodule
